wb_mux_reg: RTL and testbench

Registered-decode 1-to-N Wishbone classic/burst multiplexer with bus-error generation and a response watchdog. Sits between a single Wishbone master and `num_slaves` slaves in the wb_intercon family. It latches the target slave once per bus cycle. Unmapped addresses and hung slaves are answered with `wbm_err_o` instead of stalling the master.

---
 rtl/wb_mux_reg_pkg.sv | 16 +
 rtl/wb_mux_reg_if.sv | 29 ++
 rtl/wb_addr_decode.sv | 26 ++
 rtl/wb_mux_reg.sv | 132 +++++++++++++
 tb/tb_wb_mux_reg.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_mux_reg_pkg.sv
// Shared definitions for the wb_intercon family: FSM state encodings and CTI/BTE constants.
package wb_mux_reg_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StDerr   = 2'd2,
    StTmo    = 2'd3
  } wb_state_e;

  localparam logic [2:0] CtiClassic = 3'b000;
  localparam logic [2:0] CtiIncr    = 3'b010;
  localparam logic [2:0] CtiEob     = 3'b111;
  localparam logic [1:0] BteLinear  = 2'b00;

endpackage

// File: rtl/wb_mux_reg_if.sv
// Wishbone bus bundle; N > 1 gives the flattened multi-port form used on the slave side.
interface wb_mux_reg_if #(
  parameter int unsigned N  = 1,
  parameter int unsigned Aw = 32,
  parameter int unsigned Dw = 32
);
  logic [N*Aw-1:0]   adr;
  logic [N*Dw-1:0]   dat;
  logic [N*Dw/8-1:0] sel;
  logic [N-1:0]      we;
  logic [N-1:0]      cyc;
  logic [N-1:0]      stb;
  logic [N*3-1:0]    cti;
  logic [N*2-1:0]    bte;
  logic [N*Dw-1:0]   rdt;
  logic [N-1:0]      ack;
  logic [N-1:0]      err;
  logic [N-1:0]      rty;

  modport master (
    output adr, dat, sel, we, cyc, stb, cti, bte,
    input  rdt, ack, err, rty
  );

  modport slave (
    input  adr, dat, sel, we, cyc, stb, cti, bte,
    output rdt, ack, err, rty
  );
endinterface

// File: rtl/wb_addr_decode.sv
// Combinational priority address decoder: lowest matching slave index wins.
module wb_addr_decode #(
  parameter int unsigned          NumSlaves = 4,
  parameter int unsigned          Aw        = 32,
  parameter logic [NumSlaves*Aw-1:0] MatchAddr = '0,
  parameter logic [NumSlaves*Aw-1:0] MatchMask = '0
) (
  input  logic [Aw-1:0]        adr_i,
  output logic [NumSlaves-1:0] onehot_o,
  output logic                 hit_o
);

  always_comb begin
    onehot_o = '0;
    hit_o    = 1'b0;
    // Walk downwards so the lowest matching index is the final assignment.
    for (int i = int'(NumSlaves) - 1; i >= 0; i--) begin
      if ((adr_i & MatchMask[i*Aw +: Aw]) == MatchAddr[i*Aw +: Aw]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        hit_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_mux_reg.sv
// Registered-decode 1-to-N Wishbone mux with decode-miss errors and a response watchdog.
module wb_mux_reg
  import wb_mux_reg_pkg::*;
#(
  parameter int unsigned                 num_slaves = 4,
  parameter int unsigned                 aw         = 32,
  parameter int unsigned                 dw         = 32,
  parameter logic [num_slaves*aw-1:0]    MATCH_ADDR = '0,
  parameter logic [num_slaves*aw-1:0]    MATCH_MASK = '0,
  parameter int unsigned                 TIMEOUT    = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  wb_mux_reg_if.slave   wbm,
  wb_mux_reg_if.master  wbs,
  output logic          fault_o,
  output logic          fault_tmo_o,
  output logic [aw-1:0] fault_adr_o
);

  localparam int unsigned    CntW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  wb_state_e             state_q, state_d;
  logic [num_slaves-1:0] sel_q, sel_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  fault_tmo_q, fault_tmo_d;
  logic [aw-1:0]         fault_adr_q, fault_adr_d;

  logic [num_slaves-1:0] dec_onehot;
  logic                  dec_hit;
  logic [dw-1:0]         s_rdt;
  logic                  s_ack, s_err, s_rty, s_resp, active;

  wb_addr_decode #(
    .NumSlaves (num_slaves),
    .Aw        (aw),
    .MatchAddr (MATCH_ADDR),
    .MatchMask (MATCH_MASK)
  ) u_decode (
    .adr_i    (wbm.adr),
    .onehot_o (dec_onehot),
    .hit_o    (dec_hit)
  );

  assign wbs.adr = {num_slaves{wbm.adr}};
  assign wbs.dat = {num_slaves{wbm.dat}};
  assign wbs.sel = {num_slaves{wbm.sel}};
  assign wbs.we  = {num_slaves{wbm.we}};
  assign wbs.cti = {num_slaves{wbm.cti}};
  assign wbs.bte = {num_slaves{wbm.bte}};
  // sel_q is only non-zero in ACTIVE, so this gating also silences DERR/TMO.
  assign wbs.cyc = sel_q & {num_slaves{wbm.cyc}};
  assign wbs.stb = sel_q & {num_slaves{wbm.stb}};

  always_comb begin
    s_rdt = '0;
    for (int i = 0; i < int'(num_slaves); i++) begin
      if (sel_q[i]) s_rdt = s_rdt | wbs.rdt[i*dw +: dw];
    end
  end

  assign s_ack  = |(sel_q & wbs.ack);
  assign s_err  = |(sel_q & wbs.err);
  assign s_rty  = |(sel_q & wbs.rty);
  assign s_resp = s_ack | s_err | s_rty;
  assign active = (state_q == StActive);

  assign wbm.rdt     = active ? s_rdt : '0;
  assign wbm.ack     = active & s_ack;
  assign wbm.rty     = active & s_rty;
  assign wbm.err     = (active & s_err) | (state_q == StDerr) | (state_q == StTmo);
  assign fault_o     = (state_q == StDerr) | (state_q == StTmo);
  assign fault_tmo_o = fault_tmo_q;
  assign fault_adr_o = fault_adr_q;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = '0;
    fault_tmo_d = fault_tmo_q;
    fault_adr_d = fault_adr_q;
    case (state_q)
      StIdle: begin
        if (wbm.cyc[0] && wbm.stb[0]) begin
          if (dec_hit) begin
            sel_d   = dec_onehot;
            state_d = StActive;
          end else begin
            state_d     = StDerr;
            fault_tmo_d = 1'b0;
            fault_adr_d = wbm.adr;
          end
        end
      end
      StActive: begin
        if (!wbm.cyc[0]) begin
          state_d = StIdle;
          sel_d   = '0;
        end else if (wbm.stb[0] && !s_resp) begin
          if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
            state_d     = StTmo;
            sel_d       = '0;
            fault_tmo_d = 1'b1;
            fault_adr_d = wbm.adr;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StDerr, StTmo: state_d = StIdle;
      default:       state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      cnt_q       <= '0;
      fault_tmo_q <= 1'b0;
      fault_adr_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      fault_tmo_q <= fault_tmo_d;
      fault_adr_q <= fault_adr_d;
    end
  end

endmodule

// File: tb/tb_wb_mux_reg.sv
// Self-checking bench for wb_mux_reg: behavioural slave models plus a window/scoreboard model.
module tb_wb_mux_reg;
  import wb_mux_reg_pkg::*;

  localparam int unsigned NS  = 4;
  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_mux_reg_if #(.N(1),  .Aw(32), .Dw(32)) m_if ();
  wb_mux_reg_if #(.N(NS), .Aw(32), .Dw(32)) s_if ();

  logic        fault, fault_tmo;
  logic [31:0] fault_adr;

  wb_mux_reg #(
    .num_slaves (NS),
    .aw         (32),
    .dw         (32),
    .MATCH_ADDR ({32'h300, 32'h200, 32'h100, 32'h000}),
    .MATCH_MASK ({4{32'hffffff00}}),
    .TIMEOUT    (TMO)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .wbm         (m_if),
    .wbs         (s_if),
    .fault_o     (fault),
    .fault_tmo_o (fault_tmo),
    .fault_adr_o (fault_adr)
  );

  // Slave models: fixed wait states (or silent), 64-word memories, strobe counters.
  int          lat_cfg[NS];
  bit          silent[NS];
  int          wcnt[NS];
  int          stb_cnt[NS];
  logic [31:0] mem[NS][64];
  logic [NS-1:0] s_ack;

  always_comb begin
    s_ack    = '0;
    s_if.rdt = '0;
    for (int i = 0; i < NS; i++) begin
      s_ack[i] = s_if.cyc[i] && s_if.stb[i] && !silent[i] && (wcnt[i] == lat_cfg[i]);
      s_if.rdt[i*32 +: 32] = mem[i][s_if.adr[i*32+2 +: 6]];
    end
  end
  assign s_if.ack = s_ack;
  assign s_if.err = '0;
  assign s_if.rty = '0;

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (s_if.cyc[i] && s_if.stb[i]) begin
        stb_cnt[i] <= stb_cnt[i] + 1;
        if (s_ack[i]) begin
          wcnt[i] <= 0;
          if (s_if.we[i]) mem[i][s_if.adr[i*32+2 +: 6]] <= s_if.dat[i*32 +: 32];
        end else begin
          wcnt[i] <= wcnt[i] + 1;
        end
      end else begin
        wcnt[i] <= 0;
      end
    end
  end

  // Reference model: 256-byte windows at 0x000..0x3ff, one per slave.
  logic [31:0] exp_mem[NS][64];
  bit          exp_wr[NS][64];
  int          base_cnt[NS];
  int          n_chk = 0;
  int          n_fail = 0;

  int            r_resp, r_lat;
  logic [31:0]   r_rdt, r_sadr;
  logic [NS-1:0] r_stb, r_cyc;
  logic          r_fault, r_nxt_err, r_nxt_fault;
  int            b_lat[8], b_resp[8];
  logic [31:0]   b_rdt[8], b_wdat[8];

  task automatic snap_counts();
    for (int i = 0; i < NS; i++) base_cnt[i] = stb_cnt[i];
  endtask

  // resp: 0 none within bound, 1 ack, 2 err, 3 rty; lat counted from the request cycle.
  task automatic single(input logic [31:0] adr, input bit we, input logic [31:0] wdat);
    @(posedge clk); #1;
    m_if.adr = adr; m_if.dat = wdat; m_if.we = we; m_if.sel = 4'hf;
    m_if.cti = CtiClassic; m_if.bte = BteLinear; m_if.cyc = 1'b1; m_if.stb = 1'b1;
    r_resp = 0; r_lat = -1; r_rdt = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m_if.ack[0] || m_if.err[0] || m_if.rty[0]) begin
        r_lat   = c;
        r_resp  = m_if.ack[0] ? 1 : (m_if.err[0] ? 2 : 3);
        r_rdt   = m_if.rdt;
        r_stb   = s_if.stb;
        r_cyc   = s_if.cyc;
        r_fault = fault;
        r_sadr  = s_if.adr[3*32 +: 32];
        break;
      end
    end
    @(posedge clk); #1;
    m_if.cyc = 1'b0; m_if.stb = 1'b0;
    @(negedge clk);
    r_nxt_err   = m_if.err[0];
    r_nxt_fault = fault;
  endtask

  task automatic burst(input logic [31:0] base, input int n, input bit we);
    @(posedge clk); #1;
    m_if.cyc = 1'b1; m_if.we = we; m_if.sel = 4'hf; m_if.bte = BteLinear;
    for (int b = 0; b < n; b++) begin
      m_if.adr = base + 32'(4 * b);
      m_if.dat = b_wdat[b];
      m_if.cti = (b == n - 1) ? CtiEob : CtiIncr;
      m_if.stb = 1'b1;
      b_resp[b] = 0; b_lat[b] = -1; b_rdt[b] = '0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (m_if.ack[0] || m_if.err[0]) begin
          b_lat[b]  = c;
          b_resp[b] = m_if.ack[0] ? 1 : 2;
          b_rdt[b]  = m_if.rdt;
          break;
        end
      end
      @(posedge clk); #1;
    end
    m_if.cyc = 1'b0; m_if.stb = 1'b0; m_if.cti = CtiClassic;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (s_if.cyc !== '0 || s_if.stb !== '0) begin n_fail++;
      $display("FAIL reset_wbs: cyc=%b stb=%b want 0", s_if.cyc, s_if.stb); end
    n_chk++; if ({m_if.ack, m_if.err, m_if.rty} !== 3'b000 || m_if.rdt !== 32'h0) begin n_fail++;
      $display("FAIL reset_wbm: ack/err/rty=%b rdt=%h want 0", {m_if.ack, m_if.err, m_if.rty},
               m_if.rdt); end
    n_chk++; if ({fault, fault_tmo} !== 2'b00 || fault_adr !== 32'h0) begin n_fail++;
      $display("FAIL reset_fault: f=%b tmo=%b adr=%h want 0", fault, fault_tmo, fault_adr); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single();
    snap_counts();
    single(32'h204, 1'b1, 32'hdeadbeef);
    exp_mem[2][1] = 32'hdeadbeef; exp_wr[2][1] = 1'b1;
    n_chk++; if (r_resp !== 1 || r_lat !== 1) begin n_fail++;
      $display("FAIL single_wr: resp=%0d lat=%0d want 1/1", r_resp, r_lat); end
    n_chk++; if (r_stb !== 4'b0100 || r_cyc !== 4'b0100) begin n_fail++;
      $display("FAIL single_wr_strobe: stb=%b cyc=%b want 0100", r_stb, r_cyc); end
    n_chk++; if (r_sadr !== 32'h204) begin n_fail++;
      $display("FAIL broadcast_adr: got %h want 00000204", r_sadr); end
    n_chk++; if (stb_cnt[2] - base_cnt[2] !== 1 ||
                 stb_cnt[0] + stb_cnt[1] + stb_cnt[3] !== base_cnt[0] + base_cnt[1] + base_cnt[3])
    begin n_fail++;
      $display("FAIL single_wr_only_s2: s2 delta=%0d", stb_cnt[2] - base_cnt[2]); end
    single(32'h204, 1'b0, 32'h0);
    n_chk++; if (r_resp !== 1 || r_rdt !== exp_mem[2][1]) begin n_fail++;
      $display("FAIL single_rd: resp=%0d rdt=%h want 1/%h", r_resp, r_rdt, exp_mem[2][1]); end
  endtask

  task automatic test_burst();
    int bad;
    for (int b = 0; b < 4; b++) b_wdat[b] = $urandom;
    snap_counts();
    burst(32'h1f0, 4, 1'b1);
    bad = 0;
    for (int b = 0; b < 4; b++) begin
      exp_mem[1][60 + b] = b_wdat[b]; exp_wr[1][60 + b] = 1'b1;
      if (b_resp[b] != 1 || b_lat[b] != ((b == 0) ? 1 : 0)) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++;
      $display("FAIL burst_wr_timing: %0d bad beats, lat0=%0d lat1=%0d want 0", bad, b_lat[0],
               b_lat[1]); end
    n_chk++; if (stb_cnt[1] - base_cnt[1] !== 4) begin n_fail++;
      $display("FAIL burst_wr_beats: s1 strobes=%0d want 4", stb_cnt[1] - base_cnt[1]); end
    burst(32'h1f0, 4, 1'b0);
    bad = 0;
    for (int b = 0; b < 4; b++) if (b_resp[b] != 1 || b_rdt[b] !== exp_mem[1][60 + b]) bad++;
    n_chk++; if (bad != 0) begin n_fail++;
      $display("FAIL burst_rd_data: %0d bad beats, beat0 %h want %h", bad, b_rdt[0],
               exp_mem[1][60]); end
  endtask

  task automatic test_no_redecode();
    int bad;
    logic [31:0] a;
    for (int b = 0; b < 4; b++) b_wdat[b] = $urandom;
    snap_counts();
    burst(32'h2f8, 4, 1'b1);
    bad = 0;
    for (int b = 0; b < 4; b++) begin
      a = 32'h2f8 + 32'(4 * b);
      exp_mem[2][a[7:2]] = b_wdat[b]; exp_wr[2][a[7:2]] = 1'b1;
      if (mem[2][a[7:2]] !== b_wdat[b]) bad++;
    end
    n_chk++; if (bad != 0 || stb_cnt[3] != base_cnt[3] || stb_cnt[2] - base_cnt[2] != 4) begin
      n_fail++;
      $display("FAIL no_redecode: bad=%0d s2=%0d s3=%0d want 0/4/0", bad,
               stb_cnt[2] - base_cnt[2], stb_cnt[3] - base_cnt[3]); end
  endtask

  task automatic test_timeout();
    silent[3] = 1'b1;
    snap_counts();
    single(32'h300, 1'b0, 32'h0);
    silent[3] = 1'b0;
    n_chk++; if (r_resp !== 2 || r_lat !== int'(TMO) + 1) begin n_fail++;
      $display("FAIL tmo_err: resp=%0d lat=%0d want 2/%0d", r_resp, r_lat, TMO + 1); end
    n_chk++; if (r_stb !== '0 || r_fault !== 1'b1) begin n_fail++;
      $display("FAIL tmo_cycle: stb=%b fault=%b want 0000/1", r_stb, r_fault); end
    n_chk++; if (stb_cnt[3] - base_cnt[3] !== int'(TMO)) begin n_fail++;
      $display("FAIL tmo_strobes: got %0d want %0d", stb_cnt[3] - base_cnt[3], TMO); end
    n_chk++; if (fault_tmo !== 1'b1 || fault_adr !== 32'h300) begin n_fail++;
      $display("FAIL tmo_fault_regs: tmo=%b adr=%h want 1/300", fault_tmo, fault_adr); end
    n_chk++; if (r_nxt_err !== 1'b0 || r_nxt_fault !== 1'b0) begin n_fail++;
      $display("FAIL tmo_one_cycle: err=%b fault=%b want 0/0", r_nxt_err, r_nxt_fault); end
  endtask

  task automatic test_decode_miss();
    snap_counts();
    single(32'h400, 1'b0, 32'h0);
    n_chk++; if (r_resp !== 2 || r_lat !== 1 || r_fault !== 1'b1) begin n_fail++;
      $display("FAIL miss_err: resp=%0d lat=%0d fault=%b want 2/1/1", r_resp, r_lat, r_fault); end
    n_chk++; if (r_nxt_err !== 1'b0 || r_nxt_fault !== 1'b0) begin n_fail++;
      $display("FAIL miss_one_cycle: err=%b fault=%b want 0/0", r_nxt_err, r_nxt_fault); end
    n_chk++; if (fault_adr !== 32'h400 || fault_tmo !== 1'b0) begin n_fail++;
      $display("FAIL miss_fault_regs: adr=%h tmo=%b want 400/0", fault_adr, fault_tmo); end
    n_chk++; if (stb_cnt[0] + stb_cnt[1] + stb_cnt[2] + stb_cnt[3] !==
                 base_cnt[0] + base_cnt[1] + base_cnt[2] + base_cnt[3]) begin n_fail++;
      $display("FAIL miss_no_strobe: a slave was strobed"); end
  endtask

  task automatic test_random();
    logic [31:0] adr, wdat;
    bit          we;
    int          sidx, bad;
    for (int t = 0; t < 60; t++) begin
      adr  = $urandom_range(0, 32'h4ff) & 32'hffff_fffc;
      we   = 1'($urandom_range(0, 1));
      wdat = $urandom;
      for (int i = 0; i < NS; i++) lat_cfg[i] = $urandom_range(0, 3);
      sidx = int'(adr >> 8);
      snap_counts();
      single(adr, we, wdat);
      if (sidx < NS) begin
        bad = 0;
        for (int i = 0; i < NS; i++)
          if (stb_cnt[i] - base_cnt[i] != ((i == sidx) ? lat_cfg[i] + 1 : 0)) bad++;
        n_chk++; if (r_resp !== 1 || r_lat !== lat_cfg[sidx] + 1 || bad != 0) begin n_fail++;
          $display("FAIL rand_hit adr=%h: resp=%0d lat=%0d bad=%0d want 1/%0d/0", adr, r_resp,
                   r_lat, bad, lat_cfg[sidx] + 1); end
        if (we) begin
          exp_mem[sidx][adr[7:2]] = wdat; exp_wr[sidx][adr[7:2]] = 1'b1;
        end else if (exp_wr[sidx][adr[7:2]]) begin
          n_chk++; if (r_rdt !== exp_mem[sidx][adr[7:2]]) begin n_fail++;
            $display("FAIL rand_rd adr=%h: got %h want %h", adr, r_rdt,
                     exp_mem[sidx][adr[7:2]]); end
        end
      end else begin
        n_chk++; if (r_resp !== 2 || r_lat !== 1 || fault_adr !== adr || fault_tmo !== 1'b0)
        begin n_fail++;
          $display("FAIL rand_miss adr=%h: resp=%0d lat=%0d fadr=%h tmo=%b", adr, r_resp, r_lat,
                   fault_adr, fault_tmo); end
      end
    end
    for (int i = 0; i < NS; i++) lat_cfg[i] = 0;
  endtask

  task automatic test_ack_boundary();
    lat_cfg[3] = int'(TMO) - 1;
    single(32'h308, 1'b0, 32'h0);
    n_chk++; if (r_resp !== 1 || r_lat !== int'(TMO) || r_fault !== 1'b0) begin n_fail++;
      $display("FAIL ack_at_limit: resp=%0d lat=%0d fault=%b want 1/%0d/0", r_resp, r_lat,
               r_fault, TMO); end
    lat_cfg[3] = int'(TMO);
    single(32'h30c, 1'b0, 32'h0);
    n_chk++; if (r_resp !== 2 || r_lat !== int'(TMO) + 1 || fault_tmo !== 1'b1 ||
                 fault_adr !== 32'h30c) begin n_fail++;
      $display("FAIL ack_past_limit: resp=%0d lat=%0d tmo=%b adr=%h want 2/%0d/1/30c", r_resp,
               r_lat, fault_tmo, fault_adr, TMO + 1); end
    lat_cfg[3] = 0;
  endtask

  task automatic test_reset_mid_burst();
    bit got;
    single(32'h004, 1'b1, 32'ha5a50f0f);
    exp_mem[0][1] = 32'ha5a50f0f; exp_wr[0][1] = 1'b1;
    @(posedge clk); #1;
    m_if.adr = 32'h000; m_if.we = 1'b0; m_if.cti = CtiIncr; m_if.cyc = 1'b1; m_if.stb = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m_if.ack[0]) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    m_if.adr = 32'h004;
    @(negedge clk);
    n_chk++; if (!got || m_if.ack[0] !== 1'b1 || m_if.rdt !== 32'ha5a50f0f) begin n_fail++;
      $display("FAIL mid_burst_beat: got=%b ack=%b rdt=%h want 1/1/a5a50f0f", got, m_if.ack,
               m_if.rdt); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (s_if.cyc !== '0 || s_if.stb !== '0 || {m_if.ack, m_if.err, m_if.rty} !== 3'b0 ||
                 m_if.rdt !== 32'h0) begin n_fail++;
      $display("FAIL async_reset_bus: cyc=%b stb=%b resp=%b rdt=%h want 0", s_if.cyc, s_if.stb,
               {m_if.ack, m_if.err, m_if.rty}, m_if.rdt); end
    n_chk++; if (fault !== 1'b0 || fault_tmo !== 1'b0 || fault_adr !== 32'h0) begin n_fail++;
      $display("FAIL async_reset_fault: f=%b tmo=%b adr=%h want 0", fault, fault_tmo,
               fault_adr); end
    @(posedge clk); #1;
    m_if.cyc = 1'b0; m_if.stb = 1'b0; m_if.cti = CtiClassic;
    @(posedge clk); #1;
    rst_n = 1'b1;
    single(32'h000, 1'b1, 32'h12345678);
    n_chk++; if (r_resp !== 1 || r_lat !== 1) begin n_fail++;
      $display("FAIL post_reset_wr: resp=%0d lat=%0d want 1/1", r_resp, r_lat); end
    single(32'h000, 1'b0, 32'h0);
    n_chk++; if (r_resp !== 1 || r_rdt !== 32'h12345678) begin n_fail++;
      $display("FAIL post_reset_rd: resp=%0d rdt=%h want 1/12345678", r_resp, r_rdt); end
  endtask

  initial begin
    m_if.adr = '0; m_if.dat = '0; m_if.sel = '0; m_if.we = '0;
    m_if.cyc = '0; m_if.stb = '0; m_if.cti = CtiClassic; m_if.bte = BteLinear;
    for (int i = 0; i < NS; i++) begin
      lat_cfg[i] = 0; silent[i] = 1'b0;
      for (int j = 0; j < 64; j++) begin exp_mem[i][j] = '0; exp_wr[i][j] = 1'b0; end
    end
    test_reset();
    test_single();
    test_burst();
    test_no_redecode();
    test_timeout();
    test_decode_miss();
    test_random();
    test_ack_boundary();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: bench did not finish, checks=%0d failures=%0d", n_chk,
             n_fail);
    $fatal(1, "time limit");
  end

endmodule
